// File: rtl/ifu_fetch_if.sv
// ---------------------------------------------------------------------------
// ifu_fetch_if
//   Groups the two buses of the instruction fetch unit:
//     - instruction-memory port : inst_addr / inst_req out, inst_data in
//     - decode handshake        : out_valid / out_pc / out_inst out, out_ready in
//   modport master : the fetch unit (drives address and the decode-side entry)
//   modport slave  : the environment (ROM plus decode stage)
// ---------------------------------------------------------------------------
interface ifu_fetch_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] inst_addr;
  logic            inst_req;
  logic [XLEN-1:0] inst_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  modport master (
    output inst_addr, inst_req, out_valid, out_pc, out_inst,
    input  inst_data, out_ready
  );

  modport slave (
    input  inst_addr, inst_req, out_valid, out_pc, out_inst,
    output inst_data, out_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//   Instruction fetch unit. Owns the PC, presents it to a combinational
//   instruction ROM, captures the returned word in the same cycle and queues
//   {pc, inst} pairs in a 2-entry FIFO that decode drains over valid/ready.
//   A redirect flushes the FIFO and reloads the PC; halt stops fetching
//   permanently (until reset) while already-queued entries still drain.
//
// Ports
//   clk            system clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   bus            ifu_fetch_if.master: ROM port and decode handshake
//   redirect_valid flush and jump to redirect_pc (highest priority)
//   redirect_pc    redirect target; low two bits are dropped
//   halt           stop fetching, sticky until reset
//   halted         halt has been latched
//   misalign_err   sticky: some redirect target had pc[1:0] != 0
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ifu_fetch_if.master      bus,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             halt,
  output logic             halted,
  output logic             misalign_err
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      count_q, count_d;
  logic            head_q, head_d;
  logic            misalign_q, misalign_d;

  // FIFO storage: two slots, addressed by a one-bit head pointer.
  logic [XLEN-1:0] mem_pc   [2];
  logic [XLEN-1:0] mem_inst [2];

  logic push;
  logic deq;
  logic tail;

  // With two slots the tail is the head offset by the occupancy parity.
  // At count=2 this equals the head, which is exactly the slot being freed
  // when a push and pop coincide.
  assign tail = head_q ^ count_q[0];

  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_pc    = mem_pc[head_q];
  assign bus.out_inst  = mem_inst[head_q];
  assign bus.inst_addr = pc_q;

  assign deq  = bus.out_valid & bus.out_ready;
  // rst_n gates the request so nothing is reported as fetched while reset
  // is held, regardless of the other inputs.
  assign push = rst_n & (state_q == ST_RUN) & ~halt & ~redirect_valid &
                ((count_q != 2'd2) | deq);
  assign bus.inst_req = push;

  assign halted       = (state_q == ST_HALT);
  assign misalign_err = misalign_q;

  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    head_d     = head_q;
    misalign_d = misalign_q;

    if (redirect_valid) begin
      // Flush wins over any dequeue this cycle; the popped entry is stale.
      count_d = 2'd0;
      head_d  = 1'b0;
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      if (push) begin
        pc_d = pc_q + XLEN'(4);
      end
      count_d = count_q + 2'(push) - 2'(deq);
      if (deq) begin
        head_d = ~head_q;
      end
    end

    // Halt is independent of redirect: both may take effect together.
    if (halt) begin
      state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= XLEN'(RESET_PC);
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      misalign_q <= misalign_d;
    end
  end

  // NOTE: the FIFO payload is deliberately not reset; out_valid comes from
  // the reset count, so slot contents are never observed before a write.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]   <= pc_q;
      mem_inst[tail] <= bus.inst_data;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch
//   Directed and randomized stimulus for ifu_fetch. A reference model holds
//   the expected FIFO contents as a queue of {pc, inst} records plus the
//   expected pc, halt and misalign flags, advanced once per clock from the
//   behavioural rules. The ROM returns word index (addr - RESET_PC) / 4.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        halted;
  logic        misalign_err;

  ifu_fetch_if #(.XLEN(32)) bus ();

  ifu_fetch #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a - RESET_PC) >> 2;
  endfunction

  assign bus.inst_data = rom(bus.inst_addr);

  // Reference model state
  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic        m_halted;
  logic        m_mis;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc     = RESET_PC;
    m_halted = 1'b0;
    m_mis    = 1'b0;
  endtask

  // One clock cycle: apply inputs, compare outputs against the model,
  // advance the model across the rising edge, end at the next falling edge.
  task automatic step(input logic rv, input logic [31:0] rp, input logic h, input logic rdy);
    logic   exp_valid;
    logic   exp_deq;
    logic   exp_req;
    entry_t e;
    redirect_valid = rv;
    redirect_pc    = rp;
    halt           = h;
    bus.out_ready  = rdy;
    #1;
    exp_valid = (m_q.size() != 0);
    exp_deq   = exp_valid && rdy;
    exp_req   = !m_halted && !h && !rv && (m_q.size() < 2 || exp_deq);
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("out_pc", bus.out_pc, m_q[0].pc);
      check("out_inst", bus.out_inst, m_q[0].inst);
    end
    check("inst_req", 32'(bus.inst_req), 32'(exp_req));
    check("inst_addr", bus.inst_addr, m_pc);
    check("halted", 32'(halted), 32'(m_halted));
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
    if (rv) begin
      m_q.delete();
      m_pc = {rp[31:2], 2'b00};
      if (rp[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      if (exp_deq) void'(m_q.pop_front());
      if (exp_req) begin
        e.pc   = m_pc;
        e.inst = rom(m_pc);
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    if (h) m_halted = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    bus.out_ready  = 1'b1;
    #1;
    model_reset();
    check("rst_inst_req", 32'(bus.inst_req), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_inst_addr", bus.inst_addr, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int n, input bit allow_mis);
    logic        rv;
    logic [31:0] rp;
    logic        rdy;
    for (int i = 0; i < n; i++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rp  = $urandom;
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
      if (!allow_mis) rp[1:0] = 2'b00;
      rdy = ($urandom_range(0, 3) != 0);
      step(rv, rp, 1'b0, rdy);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    @(negedge clk);

    // 1: streaming from reset, one instruction per cycle
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1);

    // 2: back-pressure saturates the FIFO and freezes the pc
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
    check("stall_pc", bus.inst_addr, 32'h8000_0008);
    check("stall_head", bus.out_pc, 32'h8000_0000);
    check("stall_req", 32'(bus.inst_req), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

    // 3: aligned redirect while full, with decode trying to dequeue
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0100, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("redir_head", bus.out_pc, 32'h8000_0100);
    check("redir_mis", 32'(misalign_err), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

    // random traffic with aligned redirects only
    run_random(300, 1'b0);

    // 4: misaligned redirect sets the sticky error
    step(1'b1, 32'h8000_0102, 1'b0, 1'b1);
    check("mis_pc", bus.inst_addr, 32'h8000_0100);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("mis_sticky", 32'(misalign_err), 32'd1);

    // 6: pc wraps from 0xFFFF_FFFC to 0
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("wrap_first", bus.out_pc, 32'hFFFF_FFFC);
    step(1'b0, '0, 1'b0, 1'b1);
    check("wrap_second", bus.out_pc, 32'h0000_0000);
    step(1'b0, '0, 1'b0, 1'b1);

    // 5: halt pulse while full; two entries drain, then nothing more
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("halt_valid", 32'(bus.out_valid), 32'd0);
    check("halt_flag", 32'(halted), 32'd1);
    // redirect while halted: pc loads but fetch stays stopped
    step(1'b1, 32'h8000_0040, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

    // simultaneous redirect and halt
    step(1'b1, 32'h8000_0200, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

    // random traffic including misaligned targets, then reset mid-stream
    do_reset();
    run_random(300, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
